// File: rtl/decode_issue_pkg.sv
// Shared instruction-format, opcode and ALU-control definitions for the decode/issue
// stage and the downstream ALU.
package decode_issue_pkg;

  localparam logic [3:0] OPC_ADD  = 4'b0001;
  localparam logic [3:0] OPC_NAND = 4'b0010;
  localparam logic [3:0] OPC_SUB  = 4'b0011;

  localparam logic [1:0] CZ_UNCOND = 2'b00;
  localparam logic [1:0] CZ_COND_Z = 2'b01;
  localparam logic [1:0] CZ_COND_C = 2'b10;
  localparam logic [1:0] CZ_RSVD   = 2'b11;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_NAND = 2'b01;
  localparam logic [1:0] ALU_OP_SUB  = 2'b10;

  localparam int ALUC_CZ10_BIT  = 5;
  localparam int ALUC_CZ01_BIT  = 4;
  localparam int ALUC_OP_LSB    = 2;
  localparam int ALUC_EN_BIT    = 1;
  localparam int ALUC_CARRY_BIT = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;
    logic [1:0] cz;
  } instr_fields_t;

  typedef struct packed {
    logic       legal;
    logic [5:0] ctrl;
  } dec_t;

  // Bit 2 of the instruction word carries no meaning and is dropped here.
  function automatic instr_fields_t split_instr(logic [15:0] w);
    instr_fields_t f;
    f.opcode = w[15:12];
    f.ra     = w[11:9];
    f.rb     = w[8:6];
    f.rc     = w[5:3];
    f.cz     = w[1:0];
    return f;
  endfunction

  function automatic dec_t decode_ctrl(instr_fields_t f);
    dec_t       d;
    logic [1:0] op;
    logic       carry_upd;
    d         = '0;
    d.legal   = 1'b1;
    op        = ALU_OP_ADD;
    carry_upd = 1'b1;
    case (f.opcode)
      OPC_ADD:  op = ALU_OP_ADD;
      OPC_NAND: begin
        op        = ALU_OP_NAND;
        carry_upd = 1'b0;
      end
      OPC_SUB:  op = ALU_OP_SUB;
      default:  d.legal = 1'b0;
    endcase
    if (f.cz == CZ_RSVD) d.legal = 1'b0;
    if (d.legal) begin
      d.ctrl[ALUC_CZ10_BIT]        = (f.cz == CZ_COND_C);
      d.ctrl[ALUC_CZ01_BIT]        = (f.cz == CZ_COND_Z);
      d.ctrl[ALUC_OP_LSB +: 2]     = op;
      d.ctrl[ALUC_EN_BIT]          = 1'b1;
      d.ctrl[ALUC_CARRY_BIT]       = carry_upd;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port,
// with write-to-read bypass so a retiring value is visible in the same cycle.
module regfile_2r1w #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits the instruction, tracks outstanding destinations in a
// pending scoreboard, stalls on RAW/WAW hazards and registers the decoded operands.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [5:0]  out_alu_control,
  output logic [2:0]  out_dest,
  output logic        out_illegal,
  input  logic        wb_done,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        err_sticky
);

  localparam int AW = 3;

  instr_fields_t    f;
  dec_t             dec;
  logic [15:0]      rd_a;
  logic [15:0]      rd_b;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_clr;
  logic [NREGS-1:0] pend_set;
  logic             raw_a;
  logic             raw_b;
  logic             waw;
  logic             stall;
  logic             accept;

  assign f   = split_instr(in_instr);
  assign dec = decode_ctrl(f);

  regfile_2r1w #(
    .NREGS (NREGS),
    .AW    (AW),
    .DW    (16)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb_done & wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (f.ra),
    .raddr_b (f.rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    pend_clr = '0;
    if (wb_done) pend_clr[wb_addr] = 1'b1;
  end

  // A source retiring this cycle is already forwarded, so it no longer blocks.
  // WAW blocks unconditionally, which also means any same-cycle retire to rc
  // cannot belong to an older in-flight write, so the new set always wins.
  assign raw_a = pending[f.ra] & ~pend_clr[f.ra];
  assign raw_b = pending[f.rb] & ~pend_clr[f.rb];
  assign waw   = pending[f.rc];
  assign stall = raw_a | raw_b | waw;

  assign in_ready = reset_n & ~stall & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    pend_set = '0;
    if (accept && dec.legal) pend_set[f.rc] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      out_illegal     <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= '0;
      out_dest        <= '0;
      err_sticky      <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_illegal     <= ~dec.legal;
      out_a           <= rd_a;
      out_b           <= rd_b;
      out_alu_control <= dec.ctrl;
      out_dest        <= f.rc;
      if (!dec.legal) err_sticky <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
